// File: rtl/dmem_store_pkg.sv
// Shared types and constants for the data-memory store path.
package dmem_store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } st_state_e;

    // RISC-V store funct3 encodings
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Failure causes reported on st_err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/dmem_store_unit_if.sv
// Core-side store request and data-memory write port of the store unit.
//
// Handshakes:
//   request : a store is taken on a posedge where st_valid && st_ready; the
//             request fields must be stable while st_valid is high, and are
//             ignored whenever st_ready is low.
//   memory  : dmem_write stays high with stable addr/wdata/wmask until the
//             posedge that samples dmem_resp high (or the unit gives up);
//             dmem_resp is only meaningful while dmem_write is high.
//   result  : st_done or st_err pulses for exactly one cycle per store.
interface dmem_store_unit_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_done;
    logic        st_err;
    logic [1:0]  st_err_code;
    logic        stall;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_write;
    logic        dmem_resp;

    // The store unit itself
    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, dmem_resp,
        output st_ready, st_done, st_err, st_err_code, stall,
               dmem_addr, dmem_wdata, dmem_wmask, dmem_write
    );

    // Whatever drives the unit: the core plus the data memory
    modport master (
        output st_valid, st_addr, st_data, st_funct3, dmem_resp,
        input  st_ready, st_done, st_err, st_err_code, stall,
               dmem_addr, dmem_wdata, dmem_wmask, dmem_write
    );
endinterface

// File: rtl/dmem_store_unit_align.sv
// Byte-lane alignment of store data and mask, plus legality check.
module store_align
    import dmem_store_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  mask_o,
    output logic        legal_o,
    output logic [1:0]  err_code_o
);

    // Replicate the low bytes across the word and place the enables; an
    // unknown funct3 wins over any alignment problem.
    always_comb begin
        wdata_o    = data_i;
        mask_o     = 4'b0000;
        legal_o    = 1'b0;
        err_code_o = ERR_FUNCT3;
        case (funct3_i)
            F3_SB: begin
                wdata_o    = {4{data_i[7:0]}};
                mask_o     = 4'b0001 << addr_lo_i;
                legal_o    = 1'b1;
                err_code_o = ERR_NONE;
            end
            F3_SH: begin
                wdata_o    = {2{data_i[15:0]}};
                mask_o     = 4'b0011 << addr_lo_i;
                legal_o    = ~addr_lo_i[0];
                err_code_o = addr_lo_i[0] ? ERR_MISALIGN : ERR_NONE;
            end
            F3_SW: begin
                wdata_o    = data_i;
                mask_o     = 4'b1111;
                legal_o    = (addr_lo_i == 2'b00);
                err_code_o = (addr_lo_i == 2'b00) ? ERR_NONE : ERR_MISALIGN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_store_unit.sv
// Store path: accepts one store, aligns it, holds the memory write until the
// memory responds or the wait budget runs out, then reports done/error.
module dmem_store_unit
    import dmem_store_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16   // legal range 1..255
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_store_unit_if.slave   bus,
    output st_state_e          state_dbg_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    st_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        write_q, write_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic [31:0] al_wdata;
    logic [3:0]  al_mask;
    logic        al_legal;
    logic [1:0]  al_code;
    logic        accept;

    store_align u_align (
        .addr_lo_i  (bus.st_addr[1:0]),
        .funct3_i   (bus.st_funct3),
        .data_i     (bus.st_data),
        .wdata_o    (al_wdata),
        .mask_o     (al_mask),
        .legal_o    (al_legal),
        .err_code_o (al_code)
    );

    assign accept = bus.st_valid && (state_q == IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: illegal requests skip WRITE; a response beats a timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = al_legal ? WRITE : RESP;
            WRITE:   if (bus.dmem_resp || (cnt_q == CNT_LAST)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the wait counter
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        write_d = write_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 8'd0;
                    if (al_legal) begin
                        addr_d  = {bus.st_addr[31:2], 2'b00};
                        wdata_d = al_wdata;
                        mask_d  = al_mask;
                        write_d = 1'b1;
                    end else begin
                        // memory port keeps its previous contents
                        err_d  = 1'b1;
                        code_d = al_code;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.dmem_resp) begin
                    write_d = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    write_d = 1'b0;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset drops dmem_write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.st_ready    = (state_q == IDLE);
    assign bus.stall       = (state_q != IDLE);
    assign bus.st_done     = done_q;
    assign bus.st_err      = err_q;
    assign bus.st_err_code = code_q;
    assign bus.dmem_addr   = addr_q;
    assign bus.dmem_wdata  = wdata_q;
    assign bus.dmem_wmask  = mask_q;
    assign bus.dmem_write  = write_q;
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_dmem_store_unit.sv
// Randomized bench for dmem_store_unit against a lane-by-lane store model.
module tb_dmem_store_unit;
    import dmem_store_pkg::*;

    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_store_unit_if bus ();
    st_state_e state_dbg;

    dmem_store_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard: expected dmem addr, wdata, mask of each store, in order
    logic [31:0] exp_q[$];
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural store model: lane i is enabled when it lies inside the
    // n-byte access starting at byte a; each lane carries data byte i mod n.
    function automatic void model(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [2:0] f3, output bit legal,
                                  output logic [1:0] code, output logic [31:0] wd,
                                  output logic [3:0] mk);
        int n;
        int a;
        a = int'(addr % 4);
        if (f3 == 3'd0)      n = 1;
        else if (f3 == 3'd1) n = 2;
        else if (f3 == 3'd2) n = 4;
        else                 n = 0;
        wd = 32'd0;
        mk = 4'd0;
        if (n == 0) begin
            legal = 0; code = 2'b10;
        end else if (a % n != 0) begin
            legal = 0; code = 2'b01;
        end else begin
            legal = 1; code = 2'b00;
            for (int i = 0; i < 4; i++) begin
                wd[8*i +: 8] = data[8*(i % n) +: 8];
                if (i >= a && i < a + n) mk[i] = 1'b1;
            end
        end
    endfunction

    // ---------------- driver ----------------
    // resp_at: WRITE cycle (1-based) on which memory answers; 0 = never
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input int resp_at);
        bit          legal;
        logic [1:0]  code;
        logic [31:0] wd, e_addr, e_wd, e_mk;
        logic [3:0]  mk;
        logic [2:0]  exp_res;   // {err, code}; 0 means done
        int          exp_wc, wc, cyc, gaps;
        bit          fin;

        model(addr, data, f3, legal, code, wd, mk);
        if (!legal) begin
            exp_res = {1'b1, code}; exp_wc = 0;
            exp_q.push_back(prev_addr); exp_q.push_back(prev_wdata); exp_q.push_back({28'd0, prev_mask});
        end else begin
            exp_q.push_back({addr[31:2], 2'b00}); exp_q.push_back(wd); exp_q.push_back({28'd0, mk});
            if (resp_at >= 1 && resp_at <= TO) begin exp_res = 3'b000; exp_wc = resp_at; end
            else begin exp_res = {1'b1, ERR_TIMEOUT}; exp_wc = TO; end
        end

        @(negedge clk);
        check("ready_before", bus.st_ready, 1);
        bus.st_valid = 1'b1; bus.st_addr = addr; bus.st_data = data; bus.st_funct3 = f3;
        bus.dmem_resp = 1'($urandom_range(0, 1));
        @(negedge clk);
        // request inputs are junk from now on and must be ignored
        bus.st_valid = 1'($urandom_range(0, 1)); bus.st_addr = $urandom;
        bus.st_data = $urandom; bus.st_funct3 = 3'($urandom_range(0, 7));

        cyc = 1; wc = 0; gaps = 0; fin = 0;
        while (!fin && cyc < 200) begin
            if (bus.st_done || bus.st_err) begin
                fin = 1;
                bus.st_valid = 1'b0;
                bus.dmem_resp = 1'($urandom_range(0, 1));
                check("result", {bus.st_err, bus.st_err_code}, exp_res);
                check("done", bus.st_done, exp_res == 3'b000);
                check("end_cycle", cyc, exp_wc + 1);
                check("write_cycles", wc, exp_wc);
                check("write_in_resp", bus.dmem_write, 0);
                check("gaps", gaps, 0);
                e_addr = exp_q.pop_front(); e_wd = exp_q.pop_front(); e_mk = exp_q.pop_front();
                check("resp_addr", bus.dmem_addr, e_addr);
                check("resp_wdata", bus.dmem_wdata, e_wd);
                check("resp_mask", bus.dmem_wmask, e_mk);
                prev_addr = e_addr; prev_wdata = e_wd; prev_mask = e_mk[3:0];
            end else begin
                check("busy_ready", bus.st_ready, 0);
                check("busy_stall", bus.stall, 1);
                if (bus.dmem_write) begin
                    wc++;
                    check("wr_addr", bus.dmem_addr, {addr[31:2], 2'b00});
                    check("wr_wdata", bus.dmem_wdata, wd);
                    check("wr_mask", bus.dmem_wmask, mk);
                    bus.dmem_resp = (wc == resp_at);
                end else begin
                    gaps++;
                    bus.dmem_resp = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("completion_bound", 0, 1);
        @(negedge clk);
        check("ready_after", bus.st_ready, 1);
        check("stall_after", bus.stall, 0);
        check("done_cleared", bus.st_done, 0);
        check("err_cleared", bus.st_err, 0);
        check("write_idle", bus.dmem_write, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, bus.st_ready, 1);
        check({tag, "_stall"}, bus.stall, 0);
        check({tag, "_write"}, bus.dmem_write, 0);
        check({tag, "_addr"}, bus.dmem_addr, 0);
        check({tag, "_wdata"}, bus.dmem_wdata, 0);
        check({tag, "_mask"}, bus.dmem_wmask, 0);
        check({tag, "_done"}, bus.st_done, 0);
        check({tag, "_err"}, bus.st_err, 0);
        check({tag, "_code"}, bus.st_err_code, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    // Reset arrives in the second WRITE cycle of a store that never completes
    task automatic reset_mid_write();
        @(negedge clk);
        bus.st_valid = 1'b1; bus.st_addr = 32'h0000_5000; bus.st_data = 32'hCAFE_F00D;
        bus.st_funct3 = F3_SW; bus.dmem_resp = 1'b0;
        @(negedge clk);
        bus.st_valid = 1'b0;
        check("rst_pre_write", bus.dmem_write, 1);
        @(negedge clk);
        check("rst_pre_write2", bus.dmem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_done", bus.st_done, 0);
        check("rst_hold_err", bus.st_err, 0);
        check("rst_hold_write", bus.dmem_write, 0);
        rst_n = 1'b1;
        exp_q.delete();
        prev_addr = 0; prev_wdata = 0; prev_mask = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bus.st_valid = 1'b0; bus.st_addr = 0; bus.st_data = 0;
        bus.st_funct3 = 0; bus.dmem_resp = 1'b0;
        prev_addr = 0; prev_wdata = 0; prev_mask = 0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        do_store(32'h0000_1003, 32'hAABB_CC5A, F3_SB, 1);
        do_store(32'h0000_2002, 32'h1234_BEEF, F3_SH, 3);
        do_store(32'h0000_3001, 32'h0102_0304, F3_SW, 1);
        do_store(32'h0000_3001, 32'h0102_0304, 3'b011, 1);
        do_store(32'h0000_3100, 32'h5555_AAAA, F3_SW, 0);
        do_store(32'h0000_3104, 32'h7777_8888, F3_SW, TO);
        do_store(32'h0000_3201, 32'h0000_00E7, F3_SB, 2);
        do_store(32'h0000_3203, 32'h0000_BEEF, F3_SH, 1);

        reset_mid_write();
        do_store(32'h0000_4000, 32'hDEAD_BEEF, F3_SW, 1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(3, 7));
            else                           f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            do_store(a, $urandom, f3, $urandom_range(0, TO + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_store_unit.md
# dmem_store_unit

Store path of the data-memory interface: accepts one store request per transaction from the core (address, rs2 value, funct3), aligns data and byte mask for a 32-bit word-addressed data memory, and holds the write until memory responds. It is the write-side counterpart of the load path, which selects and extends returned bytes and halfwords. It sits between the core's store issue and the data-memory port and stalls the core while a write is outstanding.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles allowed in WRITE before abort; legal range 1..255.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `st_valid` in 1: core store request valid.
- `st_ready` out 1: unit can accept a request; equals (state == IDLE).
- `st_addr` in 32: byte address of the store.
- `st_data` in 32: rs2 value; low bits are used for SB/SH.
- `st_funct3` in 3: store width. 000 = SB, 001 = SH, 010 = SW; all other values are illegal.
- `st_done` out 1: one-cycle pulse on successful completion.
- `st_err` out 1: one-cycle pulse when the transaction fails.
- `st_err_code` out 2: failure cause, valid while `st_err` = 1. 01 = misaligned, 10 = illegal funct3, 11 = timeout.
- `stall` out 1: core stall; equals (state != IDLE).
- `dmem_addr` out 32: word address, `{addr[31:2], 2'b00}`.
- `dmem_wdata` out 32: aligned write data.
- `dmem_wmask` out 4: byte enables.
- `dmem_write` out 1: write request; held high until accepted or aborted.
- `dmem_resp` in 1: memory completed the write.

## Operation
- States: IDLE, WRITE, RESP.
- **Accept:** a request is accepted on a posedge where `st_valid` and `st_ready` are both 1.
- **Alignment** (`a` = `st_addr[1:0]`):
  - SB: mask = `4'b0001 << a`; wdata = `{4{st_data[7:0]}}`.
  - SH: requires `a[0]` = 0; mask = `4'b0011 << a`; wdata = `{2{st_data[15:0]}}`.
  - SW: requires `a` = 00; mask = `4'b1111`; wdata = `st_data`.
- **Legal accept:** register addr, wdata and mask; go to WRITE; clear the timeout counter.
- **Illegal accept** (misaligned or bad funct3): go directly to RESP with the error code latched. `dmem_write` never asserts, and dmem outputs stay at their previous values.
  - Bad funct3 takes priority over misalignment (code 10).
- **WRITE:** `dmem_write` = 1 and the counter increments each cycle.
  - `dmem_resp` = 1: go to RESP and mark success.
  - Counter reaches TIMEOUT - 1 with no response: go to RESP with code 11.
  - `dmem_resp` and timeout in the same cycle: response wins (success).
- **RESP:** for exactly one cycle, pulse `st_done` (success) or `st_err` plus `st_err_code` (failure); then return to IDLE.
- `dmem_resp` is ignored outside WRITE.
- Request inputs are ignored when `st_ready` = 0.
- **Reset mid-operation:** state goes to IDLE immediately and `dmem_write` drops asynchronously. No done or error pulse is emitted, and the in-flight write is abandoned.

## Timing
- **Reset values:** state IDLE; `st_ready` 1; `stall` 0; `dmem_write` 0; `dmem_addr`, `dmem_wdata`, `dmem_wmask` 0; `st_done` 0; `st_err` 0; `st_err_code` 00; counter 0.
- **Outputs:** all dmem outputs, `st_done`, `st_err` and `st_err_code` are registered. `st_ready` and `stall` are decoded from the state register.
- **Latency:**
  - Accept at edge 0 → `dmem_write` high in cycle 1.
  - `dmem_resp` sampled high at edge k → `st_done` high in cycle k+1 → `st_ready` high in cycle k+2.
  - Minimum occupancy with zero-wait memory is 3 cycles per store. There is no back-to-back accept.
  - Illegal request: accept at edge 0 → `st_err` high in cycle 1 → `st_ready` high in cycle 2.
  - Timeout: `dmem_write` is high for exactly TIMEOUT cycles → `st_err` with code 11 in the next cycle.
- `dmem_addr`, `dmem_wdata` and `dmem_wmask` are stable for the whole time `dmem_write` is high.

## Structure
- **Package `dmem_store_pkg`:**
  - `st_state_e` (IDLE, WRITE, RESP).
  - funct3 constants `F3_SB`, `F3_SH`, `F3_SW`.
  - Error codes `ERR_MISALIGN`, `ERR_FUNCT3`, `ERR_TIMEOUT`.
- **Sub-module `store_align`:** purely combinational. Takes addr[1:0], funct3 and data; produces wdata, mask, legal and err_code. The top level holds the FSM, the counter and the output registers.

## Test plan
- **SB, no wait:** SB, addr 0x1003, data 0xAABBCC5A, `dmem_resp` on the first WRITE cycle.
  - `dmem_addr` 0x1000, mask 1000, wdata 0x5A5A5A5A.
  - `st_done` in cycle 2; `st_ready` in cycle 3.
- **SH, 3 wait states:** SH, addr 0x2002, data 0x1234BEEF, resp after 3 WRITE cycles.
  - mask 1100, wdata 0xBEEFBEEF.
  - `dmem_write` is high for 3 cycles; then `st_done`.
- **Misaligned SW:** SW, addr 0x3001.
  - `dmem_write` never rises.
  - `st_err` = 1 with code 01 in cycle 1; `st_ready` in cycle 2.
- **Bad funct3:** funct3 = 011 with addr 0x3001 → code 10 (funct3 has priority); no memory write.
- **Timeout vs response:**
  - TIMEOUT = 4, no response → `dmem_write` high for 4 cycles, then `st_err` with code 11.
  - Repeat with `dmem_resp` on the 4th cycle → `st_done`, no error.
- **Reset mid-write:** assert `rst_n` = 0 during cycle 2 of WRITE.
  - `dmem_write` drops without waiting for a clock edge.
  - All outputs return to reset values; no done/error pulse.
  - After release, a new SW to 0x4000 completes normally.
